// File: rtl/wide_adder_pkg.sv
// Shared definitions for the sequential wide adder.
//   state_t : controller states (IDLE, RUN, DONE)
//   DEF_N   : default slice width in bits
//   DEF_K   : default number of chunks
package wide_adder_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_K = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_slice.sv
// N-bit combinational adder slice with group propagate/generate.
//   cin  : carry into the slice
//   a, b : slice operands
//   s    : a + b + cin, low N bits
//   cout : carry out of a + b + cin
//   prop : AND over all bits of (a ^ b)
//   gen  : carry out of a + b with the carry-in forced to 0
module adder_slice #(
  parameter int N = 4
) (
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         prop,
  output logic         gen
);

  logic [N:0]   full_sum;
  logic [N-1:0] p_bits;
  logic [N:0]   g_chain;   // ripple carry with carry-in 0, used only for gen

  assign full_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign s        = full_sum[N-1:0];
  assign cout     = full_sum[N];

  assign g_chain[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign p_bits[gi]    = a[gi] ^ b[gi];
      assign g_chain[gi+1] = (a[gi] & b[gi]) | (p_bits[gi] & g_chain[gi]);
    end
  endgenerate

  assign prop = &p_bits;
  assign gen  = g_chain[N];

endmodule

// File: rtl/seq_wide_adder_ctrl.sv
// Multi-cycle W-bit adder (W = N*K): one N-bit slice is stepped over K
// chunks, LSB chunk first, with the inter-chunk carry held in a register.
//   clk, rst_n               : clock, synchronous active-low reset
//   start_valid/start_ready  : operation request handshake (a, b, cin sampled on accept)
//   res_valid/res_ready      : result handshake
//   s, cout, prop, gen       : registered result, meaningful while res_valid=1
//   busy                     : controller not in IDLE
module seq_wide_adder_ctrl
  import wide_adder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic           cin,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N*K-1:0] s,
  output logic           cout,
  output logic           prop,
  output logic           gen,
  output logic           busy
);

  localparam int W  = N * K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, b_reg;
  logic           carry_reg;
  logic [CW-1:0]  cnt_reg;
  logic           prop_acc_reg, gen_acc_reg;
  logic [N-1:0]   s_chunk_reg [K];
  logic           cout_reg, prop_reg, gen_reg, res_valid_reg;

  logic [N-1:0]   a_chunk [K];
  logic [N-1:0]   b_chunk [K];
  logic [N-1:0]   slice_s;
  logic           slice_c, slice_p, slice_g;
  logic           accept, last_chunk;

  // Chunk views of the operand registers and of the result.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_chunk
      assign a_chunk[gi]      = a_reg[gi*N +: N];
      assign b_chunk[gi]      = b_reg[gi*N +: N];
      assign s[gi*N +: N]     = s_chunk_reg[gi];
    end
  endgenerate

  adder_slice #(.N(N)) u_slice (
    .cin  (carry_reg),
    .a    (a_chunk[cnt_reg]),
    .b    (b_chunk[cnt_reg]),
    .s    (slice_s),
    .cout (slice_c),
    .prop (slice_p),
    .gen  (slice_g)
  );

  // start_ready is held low during reset so no request is acknowledged then.
  assign start_ready = (state_reg == IDLE) & rst_n;
  assign busy        = (state_reg != IDLE);
  assign accept      = start_valid & start_ready;
  assign last_chunk  = (cnt_reg == CW'(K - 1));

  assign res_valid = res_valid_reg;
  assign cout      = cout_reg;
  assign prop      = prop_reg;
  assign gen       = gen_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)     state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (res_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      cnt_reg       <= '0;
      prop_acc_reg  <= 1'b0;
      gen_acc_reg   <= 1'b0;
      cout_reg      <= 1'b0;
      prop_reg      <= 1'b0;
      gen_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      for (int i = 0; i < K; i++) s_chunk_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg        <= a;
            b_reg        <= b;
            carry_reg    <= cin;
            cnt_reg      <= '0;
            prop_acc_reg <= 1'b1;
            gen_acc_reg  <= 1'b0;
          end
        end
        RUN: begin
          s_chunk_reg[cnt_reg] <= slice_s;
          carry_reg            <= slice_c;
          prop_acc_reg         <= prop_acc_reg & slice_p;
          gen_acc_reg          <= slice_g | (slice_p & gen_acc_reg);
          if (last_chunk) begin
            // Counter stays at K-1 rather than wrapping.
            cout_reg      <= slice_c;
            prop_reg      <= prop_acc_reg & slice_p;
            gen_reg       <= slice_g | (slice_p & gen_acc_reg);
            res_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (res_ready) res_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
module tb_seq_wide_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start_valid, start_ready, cin;
  logic [15:0] a, b, s;
  logic        res_valid, res_ready, cout, prop, gen, busy;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          lat;

  always #5 clk = ~clk;

  seq_wide_adder_ctrl #(.N(4), .K(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .cin         (cin),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .s           (s),
    .cout        (cout),
    .prop        (prop),
    .gen         (gen),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges after the accept edge until res_valid, bounded at 20.
  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        output int n);
    start_valid = 1'b1;
    a = ta; b = tb_v; cin = tc;
    tick();
    start_valid = 1'b0;
    wait_result(n);
    $display("[TB] op a=%h b=%h cin=%0d -> s=%h cout=%0d prop=%0d gen=%0d lat=%0d",
             ta, tb_v, tc, s, cout, prop, gen, n);
  endtask

  task automatic release_result(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_rv_drop"}, res_valid, 1'b0);
    check({tag, "_idle"}, start_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    check("rst_ready", start_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rv", res_valid, 1'b0);
    check("rst_s", s, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", start_ready, 1'b1);

    // 1: all-propagate chain, carry-in ripples through every chunk
    run_op(16'hFFFF, 16'h0000, 1'b1, lat);
    check("t1_lat", lat, 4);
    check("t1_s", s, 16'h0000);
    check("t1_cout", cout, 1'b1);
    check("t1_prop", prop, 1'b1);
    check("t1_gen", gen, 1'b0);
    release_result("t1");

    // 2: generate only in the top chunk
    run_op(16'h8000, 16'h8000, 1'b0, lat);
    check("t2_lat", lat, 4);
    check("t2_s", s, 16'h0000);
    check("t2_cout", cout, 1'b1);
    check("t2_gen", gen, 1'b1);
    check("t2_prop", prop, 1'b0);
    release_result("t2");

    // 3: plain sums
    run_op(16'h1234, 16'h4321, 1'b0, lat);
    check("t3a_s", s, 16'h5555);
    check("t3a_cout", cout, 1'b0);
    check("t3a_prop", prop, 1'b0);
    check("t3a_gen", gen, 1'b0);
    release_result("t3a");
    run_op(16'hA5A5, 16'h5A5A, 1'b0, lat);
    check("t3b_s", s, 16'hFFFF);
    check("t3b_prop", prop, 1'b1);
    check("t3b_gen", gen, 1'b0);
    check("t3b_cout", cout, 1'b0);
    release_result("t3b");

    // 4: backpressure with a pending new request
    run_op(16'h1111, 16'h2222, 1'b0, lat);
    check("t4_s", s, 16'h3333);
    start_valid = 1'b1;
    a = 16'h0001; b = 16'h0002; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_rv", res_valid, 1'b1);
      check("t4_hold_s", s, 16'h3333);
      check("t4_hold_ready", start_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t4_back_idle", start_ready, 1'b1);
    check("t4_rv_drop", res_valid, 1'b0);
    tick();
    start_valid = 1'b0;
    check("t4_accepted", busy, 1'b1);
    wait_result(lat);
    $display("[TB] op a=0001 b=0002 cin=1 -> s=%h cout=%0d lat=%0d", s, cout, lat);
    check("t4_lat", lat, 4);
    check("t4_new_s", s, 16'h0004);
    check("t4_new_cout", cout, 1'b0);
    release_result("t4");

    // 5: operands change every cycle during RUN
    start_valid = 1'b1;
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      tick();
      lat++;
    end
    $display("[TB] op a=0f0f b=00f1 cin=1 -> s=%h cout=%0d lat=%0d", s, cout, lat);
    check("t5_lat", lat, 4);
    check("t5_s", s, 16'h1001);
    check("t5_cout", cout, 1'b0);
    check("t5_prop", prop, 1'b0);
    release_result("t5");

    // 6: reset while cnt=2
    start_valid = 1'b1;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    check("t6_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("t6_busy", busy, 1'b0);
    check("t6_rv", res_valid, 1'b0);
    check("t6_s", s, 16'h0000);
    check("t6_cout", cout, 1'b0);
    check("t6_prop", prop, 1'b0);
    check("t6_gen", gen, 1'b0);
    check("t6_ready_low", start_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("t6_ready", start_ready, 1'b1);
    run_op(16'h00FF, 16'h0001, 1'b0, lat);
    check("t6_lat", lat, 4);
    check("t6_s_after", s, 16'h0100);
    check("t6_cout_after", cout, 1'b0);
    release_result("t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_wide_adder_ctrl.md
# seq_wide_adder_ctrl

Multi-cycle sequencer that adds two W-bit operands (W = N·K) by stepping one N-bit adder slice over K chunks, LSB chunk first, with the inter-chunk carry held in a register. It also accumulates group propagate and generate across the chunks. It sits between a requester using a valid/ready start handshake and a consumer using a valid/ready result handshake. Its purpose is to trade latency for area when a full-width adder is too large.

## Interface
Parameters:
- N, 4, slice width in bits (≥1)
- K, 4, number of chunks (≥1); W = N·K

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start_valid  in  1  requester has an operation
- start_ready  out  1  block accepts an operation
- cin  in  1  carry-in, sampled on accept
- a  in  W  operand A, sampled on accept
- b  in  W  operand B, sampled on accept
- res_valid  out  1  result available
- res_ready  in  1  consumer takes the result
- s  out  W  sum, a+b+cin mod 2^W
- cout  out  1  carry out of a+b+cin
- prop  out  1  AND over all bits of (a[i]^b[i])
- gen  out  1  carry out of a+b with cin forced to 0
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- start_ready = (state==IDLE) & rst_n. It is 0 while rst_n is low.
- IDLE:
  - On start_valid & start_ready: capture a, b, cin into a_q, b_q, carry_q.
  - Set cnt=0, prop_acc=1, gen_acc=0, then go to RUN.
- RUN, one chunk per cycle, with chunk index j=cnt. The slice computes {c,sum} = a_q[jN+:N] + b_q[jN+:N] + carry_q, plus slice p and g (g = carry of the chunk with carry-in 0).
  - s[jN+:N] ← sum
  - carry_q ← c
  - prop_acc ← prop_acc & p
  - gen_acc ← g | (p & gen_acc)
  - cnt ← cnt+1
  - When cnt==K-1: load cout←c, prop←prop_acc&p, gen←g|(p&gen_acc), and go to DONE.
- DONE:
  - res_valid=1. s, cout, prop, gen are held stable.
  - On res_ready, go to IDLE.
  - start_valid is ignored because start_ready=0.
- Inputs a, b, cin are ignored outside the accept cycle.
- Arithmetic is unsigned. cnt width is max(1, clog2(K)). cnt never wraps past K-1.
- Outputs s/cout/prop/gen keep the last result after the result handshake and until the next RUN overwrites them. They are meaningful only while res_valid=1.
- prop=1 implies gen=0.
- Reset while rst_n=0 at a clock edge, in any state including mid-RUN or DONE:
  - Go to IDLE; res_valid=0; s=0, cout=0, prop=0, gen=0.
  - cnt=0, carry_q=0, a_q=b_q=0.
  - Any in-flight operation is discarded with no partial result.

## Timing
- Accept at edge E0, where start_valid & start_ready is high.
- Chunk j is processed on edge E(j+1).
- res_valid rises after edge EK, i.e. latency K cycles from accept.
- If res_ready=1 while res_valid=1, the block returns to IDLE at the next edge and can accept again one edge later. Minimum initiation interval is K+2 cycles.
- Zero-cycle handshakes:
  - res_valid does not depend combinationally on res_ready.
  - start_ready does not depend on start_valid.
- K=1: RUN lasts one cycle; latency 1.
- All outputs are registered, except start_ready and busy, which are decoded from the state register (start_ready is also gated by rst_n).

## Structure
- Shared package `wide_adder_pkg`: state enum (IDLE, RUN, DONE), default N and K constants.
- One sub-module `adder_slice` (parameter N; ports cin, a, b, s, cout, prop, gen). It is purely combinational, with gen defined as the carry with carry-in 0. It is instantiated once.
- The controller holds the FSM, cnt, operand and carry registers, and the accumulators.

## Test plan
All scenarios use N=4, K=4, W=16.

1. a=16'hFFFF, b=0, cin=1 → s=16'h0000, cout=1, prop=1, gen=0. res_valid is high exactly 4 cycles after accept.
2. a=16'h8000, b=16'h8000, cin=0 → s=16'h0000, cout=1, gen=1, prop=0.
3. a=16'h1234, b=16'h4321, cin=0 → s=16'h5555, cout=0, prop=0, gen=0. Then a=16'hA5A5, b=16'h5A5A, cin=0 → s=16'hFFFF, prop=1, gen=0.
4. Backpressure:
   - Stimulus: hold res_ready=0 for 5 cycles in DONE, with start_valid=1 and new operands on the inputs.
   - Response: res_valid and s stay stable and start_ready stays 0. After res_ready=1, the new operation is accepted 1 edge after the block returns to IDLE.
5. Operand change during RUN: change a/b/cin every cycle after accept → the result equals the operands captured at accept.
6. Reset mid-RUN: drive rst_n=0 for one edge at cnt=2.
   - Immediately after that edge: state IDLE, res_valid=0, all outputs 0, busy=0.
   - A following operation with a=16'h00FF, b=16'h0001, cin=0 gives s=16'h0100, cout=0.
